// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing helpers for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  localparam int TIMEOUT_CYCLES_DEF = 64;

  function automatic int arb_timeout_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int ARB_TIMEOUT_W = arb_timeout_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/mem_arb_timeout.sv
// Transaction watchdog: counts busy cycles and flags expiry on the
// TIMEOUT_CYCLES-th one. Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = arb_timeout_w(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Holds at LAST so expire stays asserted until the FSM leaves the busy states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Optional watchdog abort is enabled with the MEM_ARB_TIMEOUT_EN macro.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        stall_if,
  output logic        stall_dm,
  output logic        fsm_pcsrc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_err
);

  arb_state_e state;
  arb_owner_e owner;
  arb_owner_e last_owner;
  mem_req_t   req_q;
  logic       flush_pend;
  logic       timeout;
  logic       pick_dm;
  logic       resp;
  logic       done;
  logic       if_hit;
  logic       dm_hit;
  logic       in_req;

  // Alternate on contention so neither requester can starve the other
  assign pick_dm = dm_req && (!if_req || (last_owner == OWN_IF));
  assign in_req  = (state == REQ);
  assign resp    = (state == WAIT) && mem_rvalid;
  assign done    = resp || timeout;
  assign if_hit  = done && (owner == OWN_IF) && !flush_pend && !if_flush;
  assign dm_hit  = done && (owner == OWN_DM);

  assign if_rvalid = if_hit;
  assign dm_rvalid = dm_hit;
  assign if_rdata  = (if_hit && resp) ? mem_rdata : 32'd0;
  assign dm_rdata  = (dm_hit && resp) ? mem_rdata : 32'd0;
  assign stall_if  = if_req && !if_rvalid;
  assign stall_dm  = dm_req && !dm_rvalid;
  assign fsm_pcsrc = if_rvalid;

  assign mem_req   = in_req && !timeout;
  assign mem_we    = in_req ? req_q.we    : 1'b0;
  assign mem_addr  = in_req ? req_q.addr  : 32'd0;
  assign mem_wdata = in_req ? req_q.wdata : 32'd0;
  assign mem_be    = in_req ? req_q.be    : 4'd0;

  // Transaction sequencer: arbitrate in IDLE, hold request in REQ, await response in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      req_q      <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          if (pick_dm) begin
            owner <= OWN_DM;
            req_q <= '{addr: dm_addr, wdata: dm_wdata, be: dm_be, we: dm_we};
            state <= REQ;
          end else if (if_req) begin
            owner <= OWN_IF;
            req_q <= '{addr: if_addr, wdata: 32'd0, be: 4'hF, we: 1'b0};
            state <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ, WAIT: begin
          if (if_flush && (owner == OWN_IF)) begin
            flush_pend <= 1'b1;
          end else begin
            flush_pend <= flush_pend;
          end
          if (done) begin
            state      <= IDLE;
            last_owner <= owner;
            flush_pend <= 1'b0;
          end else if (in_req && mem_gnt) begin
            state <= WAIT;
          end else begin
            state <= state;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q;
  logic abort;

  assign abort = timeout && !resp;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .enable(state != IDLE),
    .expire(timeout)
  );

  // Sticky error flag; the abort cycle itself already reports the error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign mem_err = err_q || abort;
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
  assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset and
// watchdog sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_rvalid, dm_req, dm_we, dm_rvalid;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be, mem_be;
  logic        stall_if, stall_dm, fsm_pcsrc, mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm), .fsm_pcsrc(fsm_pcsrc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ifr; logic [31:0] ifa; logic fl;
    logic dmr; logic dmw; logic [31:0] dma; logic [31:0] dmd; logic [3:0] dmb;
    logic gnt; logic rv; logic [31:0] rd;
    logic mreq; logic mwe; logic [31:0] madr; logic dmo;
    logic ifv; logic dmv; logic sif; logic sdm;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] SD = 32'h1234_5678;
  localparam logic [31:0] LD = 32'h9ABC_DEF0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string nm;
    @(negedge clk);
    if_req = v.ifr; if_addr = v.ifa; if_flush = v.fl;
    dm_req = v.dmr; dm_we = v.dmw; dm_addr = v.dma; dm_wdata = v.dmd; dm_be = v.dmb;
    mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rd;
    #2;
    nm = $sformatf("vec%0d", idx);
    chk({nm, ".mem_req"}, mem_req, v.mreq);
    if (v.mreq) begin
      chk({nm, ".mem_we"}, mem_we, v.mwe);
      chk({nm, ".mem_addr"}, mem_addr, v.madr);
      if (v.dmo) begin
        chk({nm, ".mem_be"}, mem_be, v.dmb);
        chk({nm, ".mem_wdata"}, mem_wdata, v.dmd);
      end
    end
    chk({nm, ".if_rvalid"}, if_rvalid, v.ifv);
    chk({nm, ".if_rdata"}, if_rdata, v.ifv ? v.rd : 32'd0);
    chk({nm, ".dm_rvalid"}, dm_rvalid, v.dmv);
    chk({nm, ".dm_rdata"}, dm_rdata, v.dmv ? v.rd : 32'd0);
    chk({nm, ".stall_if"}, stall_if, v.sif);
    chk({nm, ".stall_dm"}, stall_dm, v.sdm);
    chk({nm, ".fsm_pcsrc"}, fsm_pcsrc, v.ifv);
    chk({nm, ".mem_err"}, mem_err, 1'b0);
  endtask

  // Randomized traffic. The model tracks only what the protocol promises:
  // who is pending, who was served last, and where the memory handshake is.
  task automatic run_random(input int ncyc);
    int phase = 0;
    int cnt = 0;
    bit win_dm = 1'b0;
    bit last_dm = 1'b0;
    bit drop_if = 1'b0;
    bit drop_dm = 1'b0;
    bit exp_ifv, exp_dmv;
    logic [31:0] w_addr, w_wdata;
    logic [3:0] w_be;
    logic w_we;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (drop_if) if_req = 1'b0;
      if (drop_dm) dm_req = 1'b0;
      drop_if = 1'b0;
      drop_dm = 1'b0;
      if (!if_req && ($urandom_range(0, 2) == 0)) begin
        if_req = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req && ($urandom_range(0, 2) == 0)) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_be = 4'($urandom_range(1, 15));
      end
      mem_gnt = (phase == 1) ? (cnt == 0) : ($urandom_range(0, 3) == 0);
      mem_rvalid = (phase == 2) ? (cnt == 0) : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      #2;
      exp_ifv = (phase == 2) && mem_rvalid && !win_dm;
      exp_dmv = (phase == 2) && mem_rvalid && win_dm;
      chk("rnd.mem_req", mem_req, phase == 1);
      if (phase == 1) begin
        chk("rnd.mem_addr", mem_addr, w_addr);
        chk("rnd.mem_we", mem_we, w_we);
        if (win_dm) begin
          chk("rnd.mem_be", mem_be, w_be);
          chk("rnd.mem_wdata", mem_wdata, w_wdata);
        end
      end
      chk("rnd.if_rvalid", if_rvalid, exp_ifv);
      chk("rnd.if_rdata", if_rdata, exp_ifv ? mem_rdata : 32'd0);
      chk("rnd.dm_rvalid", dm_rvalid, exp_dmv);
      chk("rnd.dm_rdata", dm_rdata, exp_dmv ? mem_rdata : 32'd0);
      chk("rnd.stall_if", stall_if, if_req && !exp_ifv);
      chk("rnd.stall_dm", stall_dm, dm_req && !exp_dmv);
      chk("rnd.fsm_pcsrc", fsm_pcsrc, exp_ifv);
      chk("rnd.mem_err", mem_err, 1'b0);
      case (phase)
        0: if (if_req || dm_req) begin
          win_dm = dm_req && (!if_req || !last_dm);
          w_addr = win_dm ? dm_addr : if_addr;
          w_we = win_dm ? dm_we : 1'b0;
          w_be = dm_be;
          w_wdata = dm_wdata;
          phase = 1;
          cnt = $urandom_range(0, 2);
        end
        1: if (mem_gnt) begin
          phase = 2;
          cnt = $urandom_range(0, 2);
        end else begin
          cnt--;
        end
        default: if (mem_rvalid) begin
          last_dm = win_dm;
          if (win_dm) drop_dm = 1'b1;
          else drop_if = 1'b1;
          phase = 0;
        end else begin
          cnt--;
        end
      endcase
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #3;
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.if_rvalid", if_rvalid, 1'b0);
    chk("rst.dm_rvalid", dm_rvalid, 1'b0);
    chk("rst.stall_if", stall_if, 1'b0);
    chk("rst.fsm_pcsrc", fsm_pcsrc, 1'b0);
    chk("rst.mem_err", mem_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // minimum-latency fetch; stray mem_rvalid in IDLE is ignored
    vq.push_back('{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // two simultaneous pairs: DM first each time, then IF
    for (int p = 0; p < 2; p++) begin
      logic [31:0] fa;
      fa = (p == 0) ? 32'h104 : 32'h108;
      vq.push_back('{1'b1, fa, 1'b0, 1'b1, 1'b1, 32'h200, SD, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      vq.push_back('{1'b1, fa, 1'b0, 1'b1, 1'b1, 32'h200, SD, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
      vq.push_back('{1'b1, fa, 1'b0, 1'b1, 1'b1, 32'h200, SD, 4'hF, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      vq.push_back('{1'b1, fa, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{1'b1, fa, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, fa, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{1'b1, fa, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    // flushed fetch completes silently, next fetch is normal
    vq.push_back('{1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h6666_7777, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    // load held in REQ for 5 cycles without grant (stray rvalid ignored)
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h400, LD, 4'h3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 5; k++) begin
      vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h400, LD, 4'h3, 1'b0, (k == 2), 32'hDEAD_0000, 1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h400, LD, 4'h3, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h400, LD, 4'h3, 1'b0, 1'b1, 32'h7777_8888, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    foreach (vq[i]) apply_vec(vq[i], i);

    // reset during REQ drops mem_req without waiting for a clock
    clear_inputs();
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h500; dm_be = 4'hF;
    @(negedge clk);
    #2 chk("rstreq.pre", mem_req, 1'b1);
    #1 rst = 1'b1;
    #1 chk("rstreq.async", mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dm_req = 1'b0;

    // reset during WAIT; a late response is then ignored
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h504;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1 rst = 1'b1;
    #1 chk("rstwait.mem_req", mem_req, 1'b0);
    chk("rstwait.dm_rvalid", dm_rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0; dm_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAAD_F00D;
    #2 chk("rstwait.stale_rvalid", dm_rvalid, 1'b0);
    chk("rstwait.stale_rdata", dm_rdata, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    if_req = 1'b1; if_addr = 32'h600;
    #2 chk("rstwait.idle", mem_req, 1'b0);
    @(negedge clk);
    mem_gnt = 1'b1;
    #2 chk("rstwait.req_addr", mem_addr, 32'h600);
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    #2 chk("rstwait.if_rdata", if_rdata, 32'h0BAD_CAFE);

    do_reset();
    run_random(400);

`ifdef MEM_ARB_TIMEOUT_EN
    do_reset();
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h700; dm_be = 4'hF;
    #2 chk("to.idle", mem_req, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #2;
      if (k < 8) begin
        chk($sformatf("to.c%0d.mem_req", k), mem_req, 1'b1);
        chk($sformatf("to.c%0d.mem_err", k), mem_err, 1'b0);
        chk($sformatf("to.c%0d.dm_rvalid", k), dm_rvalid, 1'b0);
      end else begin
        chk("to.expire.dm_rvalid", dm_rvalid, 1'b1);
        chk("to.expire.dm_rdata", dm_rdata, 32'd0);
        chk("to.expire.mem_err", mem_err, 1'b1);
        chk("to.expire.mem_req", mem_req, 1'b0);
      end
    end
    @(negedge clk);
    dm_req = 1'b0;
    #2 chk("to.sticky1", mem_err, 1'b1);
    @(negedge clk);
    #2 chk("to.sticky2", mem_err, 1'b1);
    chk("to.idle_after", mem_req, 1'b0);
    do_reset();
    #2 chk("to.cleared", mem_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
